// File: rtl/elevador_planta_3pisos.sv
// Plant model of a 3-floor elevator shaft: integrates mup/mdw motor commands into a cabin
// position and produces the floor-limit sensors and sticky protocol-fault flags.
module elevador_planta_3pisos #(
  parameter int unsigned TRAVEL_STEPS = 20,
  parameter int unsigned STEP_DIV     = 4,
  parameter int unsigned ZONE         = 2,
  parameter int unsigned INIT_FLOOR   = 0,
  parameter int unsigned POS_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mup,
  input  logic             mdw,
  output logic             f1,
  output logic             f2,
  output logic             f3,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic [2:0]       fault
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [POS_W-1:0] PosBot  = '0;
  localparam logic [POS_W-1:0] PosMid  = POS_W'(TRAVEL_STEPS);
  localparam logic [POS_W-1:0] PosTop  = POS_W'(2 * TRAVEL_STEPS);
  localparam logic [POS_W-1:0] PosInit = POS_W'(INIT_FLOOR * TRAVEL_STEPS);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    CmdIdle,
    CmdUp,
    CmdDown,
    CmdBoth
  } cmd_e;

  cmd_e             cmd;
  cmd_e             prev_q, prev_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fault_q, fault_d;
  logic             moving_q, moving_d;
  logic [2:0]       sens_q, sens_d;

  function automatic logic in_zone(input logic [POS_W-1:0] p, input logic [POS_W-1:0] c);
    logic [POS_W-1:0] d;
    d = (p >= c) ? (p - c) : (c - p);
    return d < POS_W'(ZONE);
  endfunction

  always_comb begin
    cmd = CmdIdle;
    unique case ({mup, mdw})
      2'b00: cmd = CmdIdle;
      2'b10: cmd = CmdUp;
      2'b01: cmd = CmdDown;
      2'b11: cmd = CmdBoth;
      default: cmd = CmdIdle;
    endcase
  end

  always_comb begin
    pos_d    = pos_q;
    cnt_d    = '0;
    fault_d  = fault_q;
    moving_d = 1'b0;
    prev_d   = cmd;

    unique case (cmd)
      CmdBoth: fault_d[0] = 1'b1;
      CmdUp: begin
        if (pos_q == PosTop) begin
          fault_d[1] = 1'b1;
        end else begin
          moving_d = 1'b1;
          // A reversal throws away whatever the opposite direction had accumulated.
          if (prev_q == CmdDown) begin
            cnt_d = '0;
          end else if (cnt_q == CntLast) begin
            pos_d = pos_q + POS_W'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CmdDown: begin
        if (pos_q == PosBot) begin
          fault_d[2] = 1'b1;
        end else begin
          moving_d = 1'b1;
          if (prev_q == CmdUp) begin
            cnt_d = '0;
          end else if (cnt_q == CntLast) begin
            pos_d = pos_q - POS_W'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    sens_d = {in_zone(pos_d, PosTop), in_zone(pos_d, PosMid), in_zone(pos_d, PosBot)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q    <= PosInit;
      cnt_q    <= '0;
      fault_q  <= 3'b000;
      moving_q <= 1'b0;
      prev_q   <= CmdIdle;
      sens_q   <= {INIT_FLOOR == 2, INIT_FLOOR == 1, INIT_FLOOR == 0};
    end else begin
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      moving_q <= moving_d;
      prev_q   <= prev_d;
      sens_q   <= sens_d;
    end
  end

  assign pos    = pos_q;
  assign moving = moving_q;
  assign fault  = fault_q;
  assign f1     = sens_q[0];
  assign f2     = sens_q[1];
  assign f3     = sens_q[2];

endmodule

// File: tb/tb_elevador_planta_3pisos.sv
// Directed bench for the elevator plant model with default parameters (T=20, STEP_DIV=4, ZONE=2).
module tb_elevador_planta_3pisos;

  logic       clk = 1'b0;
  logic       reset;
  logic       mup;
  logic       mdw;
  logic       f1, f2, f3;
  logic [7:0] pos;
  logic       moving;
  logic [2:0] fault;

  int compared   = 0;
  int mismatched = 0;

  elevador_planta_3pisos dut (
    .clk    (clk),
    .reset  (reset),
    .mup    (mup),
    .mdw    (mdw),
    .f1     (f1),
    .f2     (f2),
    .f3     (f3),
    .pos    (pos),
    .moving (moving),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  // Inputs change just after a falling edge; n calls of tick cover exactly n rising edges.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; mup = 1'b0; mdw = 1'b0;
    tick(2);
    compared++; if (pos !== 8'd0) begin mismatched++; $display("FAIL reset_pos: got %0d want 0", pos); end
    compared++; if ({f3, f2, f1} !== 3'b001) begin mismatched++; $display("FAIL reset_sens: got %b want 001", {f3, f2, f1}); end
    compared++; if (fault !== 3'b000) begin mismatched++; $display("FAIL reset_fault: got %b want 000", fault); end
    compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL reset_moving: got %b want 0", moving); end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_climb_to_f2();
    mup = 1'b1;
    tick(4);
    compared++; if (pos !== 8'd1) begin mismatched++; $display("FAIL climb_c4_pos: got %0d want 1", pos); end
    compared++; if (moving !== 1'b1) begin mismatched++; $display("FAIL climb_moving: got %b want 1", moving); end
    tick(3);
    compared++; if ({pos, f3, f2, f1} !== {8'd1, 3'b001}) begin mismatched++; $display("FAIL climb_c7: got pos=%0d sens=%b want pos=1 sens=001", pos, {f3, f2, f1}); end
    tick(1);
    compared++; if ({pos, f3, f2, f1} !== {8'd2, 3'b000}) begin mismatched++; $display("FAIL climb_c8: got pos=%0d sens=%b want pos=2 sens=000", pos, {f3, f2, f1}); end
    tick(67);
    compared++; if ({pos, f3, f2, f1} !== {8'd18, 3'b000}) begin mismatched++; $display("FAIL climb_c75: got pos=%0d sens=%b want pos=18 sens=000", pos, {f3, f2, f1}); end
    tick(1);
    compared++; if ({pos, f3, f2, f1} !== {8'd19, 3'b010}) begin mismatched++; $display("FAIL climb_c76: got pos=%0d sens=%b want pos=19 sens=010", pos, {f3, f2, f1}); end
    tick(4);
    compared++; if ({pos, f3, f2, f1} !== {8'd20, 3'b010}) begin mismatched++; $display("FAIL climb_c80: got pos=%0d sens=%b want pos=20 sens=010", pos, {f3, f2, f1}); end
    mup = 1'b0;
    tick(1);
    compared++; if (moving !== 1'b0) begin mismatched++; $display("FAIL stop_moving: got %b want 0", moving); end
    tick(10);
    compared++; if ({pos, f3, f2, f1, fault} !== {8'd20, 3'b010, 3'b000}) begin mismatched++; $display("FAIL stop_hold: got pos=%0d sens=%b fault=%b want pos=20 sens=010 fault=000", pos, {f3, f2, f1}, fault); end
  endtask

  task automatic test_top_limit();
    mup = 1'b1;
    tick(76);
    compared++; if ({pos, f3, f2, f1} !== {8'd39, 3'b100}) begin mismatched++; $display("FAIL top_pos39: got pos=%0d sens=%b want pos=39 sens=100", pos, {f3, f2, f1}); end
    tick(4);
    compared++; if ({pos, moving, fault} !== {8'd40, 1'b1, 3'b000}) begin mismatched++; $display("FAIL top_pos40: got pos=%0d mv=%b fault=%b want pos=40 mv=1 fault=000", pos, moving, fault); end
    tick(1);
    compared++; if ({pos, moving, fault} !== {8'd40, 1'b0, 3'b010}) begin mismatched++; $display("FAIL top_block: got pos=%0d mv=%b fault=%b want pos=40 mv=0 fault=010", pos, moving, fault); end
    tick(5);
    compared++; if ({pos, f3, f2, f1, fault} !== {8'd40, 3'b100, 3'b010}) begin mismatched++; $display("FAIL top_hold: got pos=%0d sens=%b fault=%b want pos=40 sens=100 fault=010", pos, {f3, f2, f1}, fault); end
    mup = 1'b0;
    tick(1);
  endtask

  task automatic test_both_motors();
    mdw = 1'b1;
    tick(8);
    compared++; if (pos !== 8'd38) begin mismatched++; $display("FAIL both_pre_pos: got %0d want 38", pos); end
    tick(2);
    mup = 1'b1;
    tick(1);
    compared++; if ({pos, moving, fault} !== {8'd38, 1'b0, 3'b011}) begin mismatched++; $display("FAIL both_hit: got pos=%0d mv=%b fault=%b want pos=38 mv=0 fault=011", pos, moving, fault); end
    mup = 1'b0;
    tick(3);
    compared++; if (pos !== 8'd38) begin mismatched++; $display("FAIL both_cnt_cleared: got %0d want 38", pos); end
    tick(1);
    compared++; if ({pos, fault} !== {8'd37, 3'b011}) begin mismatched++; $display("FAIL both_resume: got pos=%0d fault=%b want pos=37 fault=011", pos, fault); end
    mdw = 1'b0;
    tick(1);
  endtask

  task automatic test_reversal();
    mup = 1'b1;
    tick(3);
    compared++; if (pos !== 8'd37) begin mismatched++; $display("FAIL rev_up3: got %0d want 37", pos); end
    mup = 1'b0; mdw = 1'b1;
    tick(1);
    compared++; if (pos !== 8'd37) begin mismatched++; $display("FAIL rev_nostep: got %0d want 37", pos); end
    tick(3);
    compared++; if (pos !== 8'd37) begin mismatched++; $display("FAIL rev_wait: got %0d want 37", pos); end
    tick(1);
    compared++; if ({pos, moving} !== {8'd36, 1'b1}) begin mismatched++; $display("FAIL rev_step: got pos=%0d mv=%b want pos=36 mv=1", pos, moving); end
  endtask

  task automatic test_bottom_limit();
    tick(144);
    compared++; if ({pos, f3, f2, f1} !== {8'd0, 3'b001}) begin mismatched++; $display("FAIL bot_pos0: got pos=%0d sens=%b want pos=0 sens=001", pos, {f3, f2, f1}); end
    tick(1);
    compared++; if ({pos, moving, fault} !== {8'd0, 1'b0, 3'b111}) begin mismatched++; $display("FAIL bot_block: got pos=%0d mv=%b fault=%b want pos=0 mv=0 fault=111", pos, moving, fault); end
    mdw = 1'b0;
    tick(1);
  endtask

  task automatic test_glitch();
    mup = 1'b1;
    tick(3);
    mup = 1'b0;
    tick(2);
    compared++; if ({pos, f3, f2, f1} !== {8'd0, 3'b001}) begin mismatched++; $display("FAIL glitch_nomove: got pos=%0d sens=%b want pos=0 sens=001", pos, {f3, f2, f1}); end
  endtask

  task automatic test_async_reset();
    mup = 1'b1;
    tick(108);
    compared++; if ({pos, f3, f2, f1} !== {8'd27, 3'b000}) begin mismatched++; $display("FAIL arst_pre: got pos=%0d sens=%b want pos=27 sens=000", pos, {f3, f2, f1}); end
    #2 reset = 1'b0;
    #1;
    compared++; if ({pos, f3, f2, f1} !== {8'd0, 3'b001}) begin mismatched++; $display("FAIL arst_pos: got pos=%0d sens=%b want pos=0 sens=001", pos, {f3, f2, f1}); end
    compared++; if ({fault, moving} !== 4'b0000) begin mismatched++; $display("FAIL arst_flags: got fault=%b mv=%b want fault=000 mv=0", fault, moving); end
    mup = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    compared++; if (pos !== 8'd0) begin mismatched++; $display("FAIL arst_after: got %0d want 0", pos); end
  endtask

  initial begin
    test_reset();
    test_climb_to_f2();
    test_top_limit();
    test_both_motors();
    test_reversal();
    test_bottom_limit();
    test_glitch();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
